muladd_pipe: RTL and testbench
==============================

Name: muladd_pipe

Overview:
Parametrised successor to the fixed 8x8+20 fabric multiply-add primitive. Adds:
- configurable operand and accumulator widths;
- signed or unsigned arithmetic;
- an optional input register stage;
- a valid/ready handshake with pipeline stall;
- a per-beat accumulator clear that travels with its data.

It sits in the fabric as a hard DSP tile, fed by and feeding fabric routing like the existing MULADD.

Parameters:
A_WIDTH, 8, operand A width (2..16)
B_WIDTH, 8, operand B width (2..16)
C_WIDTH, 20, addend / accumulator / result width; must be >= A_WIDTH+B_WIDTH, else elaboration error
SIGNED, 0, 1 = two's-complement operands and product sign-extended; 0 = unsigned, zero-extended
IN_REG, 0, 1 = register A, B, C, CLR and IN_VALID in stage S0 (+1 cycle latency)
ACC_MODE, 0, 0 = Q = A*B + C; 1 = accumulate Q = acc + A*B

Ports:
UserCLK  in  1  fabric user clock, rising edge
RESET_N  in  1  asynchronous active-low reset
IN_VALID  in  1  operand beat valid
IN_READY  out  1  tile can accept a beat this cycle
A  in  A_WIDTH  multiplicand
B  in  B_WIDTH  multiplier
C  in  C_WIDTH  addend (ACC_MODE=0) or accumulator seed value (ACC_MODE=1, with CLR)
CLR  in  1  ACC_MODE=1: this beat reloads the accumulator from C; ignored when ACC_MODE=0
OUT_VALID  out  1  Q holds a result
OUT_READY  in  1  consumer accepts Q
Q  out  C_WIDTH  result
OVF  out  1  sticky: the result on Q overflowed or saturated

Behaviour:
- Reset (async assert, sync deassert at the fabric boundary): every pipeline register cleared, OUT_VALID=0, Q=0, OVF=0, accumulator=0. IN_READY=1 as soon as RESET_N is high.
- Stall rule: advance = !OUT_VALID || OUT_READY. IN_READY = advance (combinational). All stages move together only when advance=1; otherwise every stage holds.
- Accepted beat: IN_VALID && IN_READY.
- Pipeline:
  - S0 (only if IN_REG=1): captures A, B, C, CLR and valid.
  - S1: product P = A*B at full A_WIDTH+B_WIDTH, then sign- or zero-extended to C_WIDTH per SIGNED. Carries C, CLR and valid.
  - S2: output register. Latency from accept to OUT_VALID is 2+IN_REG cycles when there is no stall.
- S2 update, on advance with a valid S1 beat:
  - ACC_MODE=0: Q <= P + C.
  - ACC_MODE=1: acc <= (CLR ? C : acc) + P, and Q <= the new acc.
- Bubbles: an invalid S1 beat on advance clears OUT_VALID. Q and acc hold their values. Results are never duplicated or dropped.
- Overflow: arithmetic is modulo 2^C_WIDTH. OVF is set for the beat whose add overflows, judged per SIGNED (signed: sign overflow; unsigned: carry out). In ACC_MODE=1, OVF stays set until a CLR beat reaches S2. In ACC_MODE=0 it is per beat.
- CLR on the very first beat after reset: acc = C + P. A CLR beat never adds the old acc.
- Back-to-back accepted beats at full throughput: one result per cycle while OUT_READY=1.
- OUT_READY=0 with OUT_VALID=1:
  - Q, OVF and acc are frozen.
  - IN_READY=0.
  - Beats already inside S0/S1 are held, not lost.
- Reset mid-operation: all in-flight beats are discarded and the accumulator returns to 0.

Optional Feature:
MULADD_PIPE_SAT_EN.
- Defined: an overflowing add clamps to the extreme value instead of wrapping:
  - SIGNED=1: max 2^(C_WIDTH-1)-1 or min -2^(C_WIDTH-1).
  - SIGNED=0: max 2^C_WIDTH-1.
  - In ACC_MODE=1 the clamped value is also written back to acc.
  - OVF is set as in the wrapping case.
- Not defined: wrapping arithmetic only, and no saturation logic is synthesised.

Decomposition:
- Package muladd_pipe_pkg holds:
  - localparams for the ACC_MODE encodings;
  - function ext_product (sign/zero extension to C_WIDTH);
  - function add_ovf (sum plus overflow flag for a given SIGNED);
  - the saturation limit constants, under the macro.
- One sub-module, muladd_pipe_acc: the S2 adder / accumulator / saturation / OVF stage. It takes P, C, CLR, valid and advance.
- The top level handles S0, S1 and the handshake.

Test Plan:
1. ACC_MODE=0, SIGNED=0, IN_REG=0, OUT_READY=1: A=200, B=100, C=5 -> Q=20005 exactly 2 cycles after accept, OUT_VALID for one cycle, OVF=0.
2. SIGNED=1, A=-3 (8'hFD), B=7, C=0 -> Q=-21 (20'hFFFEB). Repeat with IN_REG=1 -> same Q, 3-cycle latency.
3. ACC_MODE=1: beats (A=2,B=3,CLR=1,C=10), (A=4,B=5,CLR=0), (A=1,B=1,CLR=0) -> Q = 16, 36, 37. A fourth beat with CLR=1, C=0, A=B=0 -> Q=0.
4. Stall: a 4-beat burst with OUT_READY=0 for 3 cycles after the first result:
   - IN_READY=0 throughout the stall;
   - Q is held stable;
   - all 4 results are delivered in order after release, with no duplicates.
5. Unsigned accumulate near the top: C_WIDTH=20, seed C=20'hFFFF0, add A=B=8 -> wraps to 20'h00030 with OVF=1. With MULADD_PIPE_SAT_EN -> Q=20'hFFFFF, OVF=1.
6. Assert RESET_N=0 with 2 beats in flight and acc=50 -> OUT_VALID=0, Q=0, OVF=0 immediately. After release, a beat (2,2,CLR=0) yields Q=4.

Source files
------------

// File: rtl/muladd_pipe_pkg.sv
// Shared encodings and arithmetic helpers for the muladd_pipe DSP tile.
// Saturation limits are only compiled in when MULADD_PIPE_SAT_EN is defined.
package muladd_pipe_pkg;

  localparam int unsigned ACC_MODE_MULADD = 0;
  localparam int unsigned ACC_MODE_ACCUM  = 1;

  // Helpers work on a fixed maximum width; callers truncate to their own width.
  localparam int unsigned MAX_W  = 64;
  localparam int unsigned MAX_W1 = MAX_W + 1;

  typedef struct packed {
    logic             ovf;
    logic [MAX_W-1:0] sum;
  } add_res_t;

  function automatic logic [MAX_W-1:0] width_mask(input int unsigned w);
    logic [MAX_W-1:0] m;
    m = (w >= MAX_W) ? {MAX_W{1'b1}} : ((MAX_W'(1) << w) - MAX_W'(1));
    return m;
  endfunction

  function automatic logic msb_at(input logic [MAX_W-1:0] x, input int unsigned w);
    return |(x & (MAX_W'(1) << (w - 1)));
  endfunction

  // Sign- or zero-extend a pw-bit product to the full helper width.
  function automatic logic [MAX_W-1:0] ext_product(input logic [MAX_W-1:0] p,
                                                    input int unsigned     pw,
                                                    input logic            sgn);
    logic [MAX_W-1:0] m;
    logic             s;
    m = width_mask(pw);
    s = sgn & msb_at(p, pw);
    return (p & m) | (s ? ~m : {MAX_W{1'b0}});
  endfunction

  // w-bit modulo add; ovf is sign overflow when sgn, carry out otherwise.
  function automatic add_res_t add_ovf(input logic [MAX_W-1:0] a,
                                       input logic [MAX_W-1:0] b,
                                       input int unsigned      w,
                                       input logic             sgn);
    logic [MAX_W-1:0] m;
    logic [MAX_W-1:0] am;
    logic [MAX_W-1:0] bm;
    logic [MAX_W:0]   s;
    add_res_t         r;
    m     = width_mask(w);
    am    = a & m;
    bm    = b & m;
    s     = {1'b0, am} + {1'b0, bm};
    r.sum = s[MAX_W-1:0] & m;
    if (sgn) begin
      r.ovf = (msb_at(am, w) == msb_at(bm, w)) && (msb_at(r.sum, w) != msb_at(am, w));
    end else begin
      r.ovf = |(s & (MAX_W1'(1) << w));
    end
    return r;
  endfunction

`ifdef MULADD_PIPE_SAT_EN
  // Clamp value for an overflowing w-bit add; neg selects the signed minimum.
  function automatic logic [MAX_W-1:0] sat_limit(input int unsigned w,
                                                 input logic        sgn,
                                                 input logic        neg);
    logic [MAX_W-1:0] m;
    logic [MAX_W-1:0] r;
    m = width_mask(w);
    if (!sgn) begin
      r = m;
    end else if (neg) begin
      r = MAX_W'(1) << (w - 1);
    end else begin
      r = m >> 1;
    end
    return r;
  endfunction
`endif

endpackage

// File: rtl/muladd_pipe_acc.sv
// S2 stage of muladd_pipe: adder, accumulator, optional saturation and OVF flag.
// Saturation is present only when MULADD_PIPE_SAT_EN is defined.
module muladd_pipe_acc
  import muladd_pipe_pkg::*;
#(
  parameter int unsigned C_WIDTH  = 20,
  parameter int unsigned SIGNED   = 0,
  parameter int unsigned ACC_MODE = 0
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               i_advance,
  input  logic               i_valid,
  input  logic [C_WIDTH-1:0] i_p,
  input  logic [C_WIDTH-1:0] i_c,
  input  logic               i_clr,
  output logic               o_valid,
  output logic [C_WIDTH-1:0] o_q,
  output logic               o_ovf
);

  logic               r_valid;
  logic [C_WIDTH-1:0] r_q;
  logic               r_ovf;

  logic               w_accumulate;
  logic [C_WIDTH-1:0] w_base;
  logic [C_WIDTH-1:0] w_res;
  logic               w_ovf_nxt;
  add_res_t           w_add;
  logic               w_unused;

  // In accumulate mode Q always equals acc, so r_q doubles as the accumulator.
  always_comb begin
    w_accumulate = (ACC_MODE == ACC_MODE_ACCUM) && !i_clr;
    w_base       = w_accumulate ? r_q : i_c;
    w_add        = add_ovf(MAX_W'(w_base), MAX_W'(i_p), C_WIDTH, SIGNED != 0);
    w_res        = C_WIDTH'(w_add.sum);
`ifdef MULADD_PIPE_SAT_EN
    if (w_add.ovf) begin
      w_res = C_WIDTH'(sat_limit(C_WIDTH, SIGNED != 0, w_base[C_WIDTH-1]));
    end
`endif
    w_ovf_nxt    = w_add.ovf | (w_accumulate & r_ovf);
  end

  assign w_unused = ^w_add;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid <= 1'b0;
      r_q     <= '0;
      r_ovf   <= 1'b0;
    end else if (i_advance) begin
      r_valid <= i_valid;
      if (i_valid) begin
        r_q   <= w_res;
        r_ovf <= w_ovf_nxt;
      end
    end
  end

  assign o_valid = r_valid;
  assign o_q     = r_q;
  assign o_ovf   = r_ovf;

endmodule

// File: rtl/muladd_pipe.sv
// Pipelined multiply-add / accumulate DSP tile with valid/ready stall handshake.
// Optional saturation is enabled by defining MULADD_PIPE_SAT_EN.
module muladd_pipe
  import muladd_pipe_pkg::*;
#(
  parameter int unsigned A_WIDTH  = 8,
  parameter int unsigned B_WIDTH  = 8,
  parameter int unsigned C_WIDTH  = 20,
  parameter int unsigned SIGNED   = 0,
  parameter int unsigned IN_REG   = 0,
  parameter int unsigned ACC_MODE = 0
) (
  input  logic               UserCLK,
  input  logic               RESET_N,
  input  logic               IN_VALID,
  output logic               IN_READY,
  input  logic [A_WIDTH-1:0] A,
  input  logic [B_WIDTH-1:0] B,
  input  logic [C_WIDTH-1:0] C,
  input  logic               CLR,
  output logic               OUT_VALID,
  input  logic               OUT_READY,
  output logic [C_WIDTH-1:0] Q,
  output logic               OVF
);

  localparam int unsigned P_WIDTH = A_WIDTH + B_WIDTH;

  if (A_WIDTH < 2 || A_WIDTH > 16 || B_WIDTH < 2 || B_WIDTH > 16) begin : g_bad_ab
    $error("muladd_pipe: A_WIDTH and B_WIDTH must be in 2..16");
  end
  if (C_WIDTH < P_WIDTH || C_WIDTH > MAX_W) begin : g_bad_c
    $error("muladd_pipe: C_WIDTH must be >= A_WIDTH+B_WIDTH and <= %0d", MAX_W);
  end

  logic               w_advance;
  logic               w_s0_valid;
  logic [A_WIDTH-1:0] w_s0_a;
  logic [B_WIDTH-1:0] w_s0_b;
  logic [C_WIDTH-1:0] w_s0_c;
  logic               w_s0_clr;
  logic [P_WIDTH-1:0] w_a_ext;
  logic [P_WIDTH-1:0] w_b_ext;
  logic [P_WIDTH-1:0] w_prod;

  logic               r_s1_valid;
  logic [C_WIDTH-1:0] r_s1_p;
  logic [C_WIDTH-1:0] r_s1_c;
  logic               r_s1_clr;

  // Every stage moves together; IN_READY is the shared advance.
  assign w_advance = !OUT_VALID || OUT_READY;
  assign IN_READY  = w_advance;

  if (IN_REG != 0) begin : g_s0
    logic               r_s0_valid;
    logic [A_WIDTH-1:0] r_s0_a;
    logic [B_WIDTH-1:0] r_s0_b;
    logic [C_WIDTH-1:0] r_s0_c;
    logic               r_s0_clr;

    always_ff @(posedge UserCLK or negedge RESET_N) begin
      if (!RESET_N) begin
        r_s0_valid <= 1'b0;
        r_s0_a     <= '0;
        r_s0_b     <= '0;
        r_s0_c     <= '0;
        r_s0_clr   <= 1'b0;
      end else if (w_advance) begin
        r_s0_valid <= IN_VALID;
        r_s0_a     <= A;
        r_s0_b     <= B;
        r_s0_c     <= C;
        r_s0_clr   <= CLR;
      end
    end

    assign w_s0_valid = r_s0_valid;
    assign w_s0_a     = r_s0_a;
    assign w_s0_b     = r_s0_b;
    assign w_s0_c     = r_s0_c;
    assign w_s0_clr   = r_s0_clr;
  end else begin : g_s0_bypass
    assign w_s0_valid = IN_VALID;
    assign w_s0_a     = A;
    assign w_s0_b     = B;
    assign w_s0_c     = C;
    assign w_s0_clr   = CLR;
  end

  // Extending both operands to P_WIDTH first makes one unsigned multiplier serve both modes.
  assign w_a_ext = (SIGNED != 0) ? {{B_WIDTH{w_s0_a[A_WIDTH-1]}}, w_s0_a}
                                 : {{B_WIDTH{1'b0}}, w_s0_a};
  assign w_b_ext = (SIGNED != 0) ? {{A_WIDTH{w_s0_b[B_WIDTH-1]}}, w_s0_b}
                                 : {{A_WIDTH{1'b0}}, w_s0_b};
  assign w_prod  = w_a_ext * w_b_ext;

  always_ff @(posedge UserCLK or negedge RESET_N) begin
    if (!RESET_N) begin
      r_s1_valid <= 1'b0;
      r_s1_p     <= '0;
      r_s1_c     <= '0;
      r_s1_clr   <= 1'b0;
    end else if (w_advance) begin
      r_s1_valid <= w_s0_valid;
      r_s1_p     <= C_WIDTH'(ext_product(MAX_W'(w_prod), P_WIDTH, SIGNED != 0));
      r_s1_c     <= w_s0_c;
      r_s1_clr   <= w_s0_clr;
    end
  end

  muladd_pipe_acc #(
    .C_WIDTH  (C_WIDTH),
    .SIGNED   (SIGNED),
    .ACC_MODE (ACC_MODE)
  ) u_acc (
    .clk       (UserCLK),
    .rst_n     (RESET_N),
    .i_advance (w_advance),
    .i_valid   (r_s1_valid),
    .i_p       (r_s1_p),
    .i_c       (r_s1_c),
    .i_clr     (r_s1_clr),
    .o_valid   (OUT_VALID),
    .o_q       (Q),
    .o_ovf     (OVF)
  );

endmodule

// File: tb/tb_muladd_pipe.sv
// Self-checking bench for muladd_pipe: four configurations, table vectors plus
// stall and mid-flight reset sequences; expectations follow MULADD_PIPE_SAT_EN.
`timescale 1ns/1ps
module tb_muladd_pipe;

  localparam int unsigned AW = 8;
  localparam int unsigned BW = 8;
  localparam int unsigned CW = 20;
  localparam int          NI = 4;
  localparam int          NV = 18;
`ifdef MULADD_PIPE_SAT_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  typedef struct {
    logic [CW-1:0] q;
    logic          ovf;
    int            lat;
    int            t_acc;
  } exp_t;

  typedef struct {
    int            k;
    logic [AW-1:0] a;
    logic [BW-1:0] b;
    logic [CW-1:0] c;
    logic          clr;
    logic [CW-1:0] q;
    logic          ovf;
  } vec_t;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [AW-1:0] a;
  logic [BW-1:0] b;
  logic [CW-1:0] c;
  logic          clr;
  logic [NI-1:0] iv;
  logic [NI-1:0] ordy;
  logic [NI-1:0] ir;
  logic [NI-1:0] ov;
  logic [NI-1:0] ovf;
  logic [CW-1:0] q [NI];

  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;
  exp_t sb [NI][$];
  vec_t tbl [NV];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // u0: unsigned muladd, u1: signed muladd, u2: signed with input register, u3: unsigned accumulate
  muladd_pipe #(.A_WIDTH(AW), .B_WIDTH(BW), .C_WIDTH(CW), .SIGNED(0), .IN_REG(0), .ACC_MODE(0)) u0 (
    .UserCLK(clk), .RESET_N(rst_n), .IN_VALID(iv[0]), .IN_READY(ir[0]), .A(a), .B(b), .C(c),
    .CLR(clr), .OUT_VALID(ov[0]), .OUT_READY(ordy[0]), .Q(q[0]), .OVF(ovf[0]));
  muladd_pipe #(.A_WIDTH(AW), .B_WIDTH(BW), .C_WIDTH(CW), .SIGNED(1), .IN_REG(0), .ACC_MODE(0)) u1 (
    .UserCLK(clk), .RESET_N(rst_n), .IN_VALID(iv[1]), .IN_READY(ir[1]), .A(a), .B(b), .C(c),
    .CLR(clr), .OUT_VALID(ov[1]), .OUT_READY(ordy[1]), .Q(q[1]), .OVF(ovf[1]));
  muladd_pipe #(.A_WIDTH(AW), .B_WIDTH(BW), .C_WIDTH(CW), .SIGNED(1), .IN_REG(1), .ACC_MODE(0)) u2 (
    .UserCLK(clk), .RESET_N(rst_n), .IN_VALID(iv[2]), .IN_READY(ir[2]), .A(a), .B(b), .C(c),
    .CLR(clr), .OUT_VALID(ov[2]), .OUT_READY(ordy[2]), .Q(q[2]), .OVF(ovf[2]));
  muladd_pipe #(.A_WIDTH(AW), .B_WIDTH(BW), .C_WIDTH(CW), .SIGNED(0), .IN_REG(0), .ACC_MODE(1)) u3 (
    .UserCLK(clk), .RESET_N(rst_n), .IN_VALID(iv[3]), .IN_READY(ir[3]), .A(a), .B(b), .C(c),
    .CLR(clr), .OUT_VALID(ov[3]), .OUT_READY(ordy[3]), .Q(q[3]), .OVF(ovf[3]));

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  function automatic int pending();
    int s = 0;
    for (int k = 0; k < NI; k++) s += sb[k].size();
    return s;
  endfunction

  // Output monitor: every handshaken result is popped from its scoreboard
  always @(negedge clk) begin
    if (rst_n) begin
      for (int k = 0; k < NI; k++) begin
        if (ov[k] && ordy[k]) begin
          exp_t e;
          if (sb[k].size() == 0) begin
            total++;
            bad++;
            $display("FAIL extra_out_u%0d: got q=%0h want no result", k, q[k]);
          end else begin
            e = sb[k].pop_front();
            check($sformatf("q_u%0d", k), 64'(q[k]), 64'(e.q));
            check($sformatf("ovf_u%0d", k), 64'(ovf[k]), 64'(e.ovf));
            if (e.lat >= 0) check($sformatf("lat_u%0d", k), 64'(cyc - e.t_acc), 64'(e.lat));
          end
        end
      end
    end
  end

  task automatic send(input int k, input logic [AW-1:0] ta, input logic [BW-1:0] tb,
                      input logic [CW-1:0] tc, input logic tclr, input logic [CW-1:0] eq,
                      input logic eovf, input int lat, input bit push);
    int n;
    @(posedge clk);
    #1;
    a     = ta;
    b     = tb;
    c     = tc;
    clr   = tclr;
    iv[k] = 1'b1;
    n     = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!ir[k] && n < 50);
    if (!ir[k]) begin
      total++;
      bad++;
      $display("FAIL accept_timeout_u%0d: got in_ready=0 want 1 within 50 cycles", k);
    end else if (push) begin
      sb[k].push_back('{q: eq, ovf: eovf, lat: lat, t_acc: cyc});
    end
  endtask

  task automatic idle(input int k);
    @(posedge clk);
    #1;
    iv[k] = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (pending() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("drain_pending", 64'(pending()), 64'd0);
    repeat (4) @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0]  = '{0, 8'hC8, 8'h64, 20'h00005, 1'b0, 20'h04E25, 1'b0};
    tbl[1]  = '{0, 8'hFF, 8'hFF, 20'hFFFFF, 1'b0, SAT ? 20'hFFFFF : 20'h0FE00, 1'b1};
    tbl[2]  = '{0, 8'h00, 8'h00, 20'h00007, 1'b1, 20'h00007, 1'b0};
    tbl[3]  = '{0, 8'h0F, 8'h10, 20'h00100, 1'b0, 20'h001F0, 1'b0};
    tbl[4]  = '{1, 8'hFD, 8'h07, 20'h00000, 1'b0, 20'hFFFEB, 1'b0};
    tbl[5]  = '{1, 8'h80, 8'h80, 20'h7FFFF, 1'b0, SAT ? 20'h7FFFF : 20'h83FFF, 1'b1};
    tbl[6]  = '{1, 8'h80, 8'h7F, 20'h80000, 1'b0, SAT ? 20'h80000 : 20'h7C080, 1'b1};
    tbl[7]  = '{1, 8'hFF, 8'hFF, 20'hFFFFF, 1'b0, 20'h00000, 1'b0};
    tbl[8]  = '{2, 8'hFD, 8'h07, 20'h00000, 1'b0, 20'hFFFEB, 1'b0};
    tbl[9]  = '{2, 8'h0A, 8'h0A, 20'h00005, 1'b0, 20'h00069, 1'b0};
    tbl[10] = '{3, 8'h02, 8'h03, 20'h0000A, 1'b1, 20'h00010, 1'b0};
    tbl[11] = '{3, 8'h04, 8'h05, 20'h003E7, 1'b0, 20'h00024, 1'b0};
    tbl[12] = '{3, 8'h01, 8'h01, 20'h00000, 1'b0, 20'h00025, 1'b0};
    tbl[13] = '{3, 8'h00, 8'h00, 20'h00000, 1'b1, 20'h00000, 1'b0};
    tbl[14] = '{3, 8'h00, 8'h00, 20'hFFFF0, 1'b1, 20'hFFFF0, 1'b0};
    tbl[15] = '{3, 8'h08, 8'h08, 20'h00000, 1'b0, SAT ? 20'hFFFFF : 20'h00030, 1'b1};
    tbl[16] = '{3, 8'h01, 8'h01, 20'h00000, 1'b0, SAT ? 20'hFFFFF : 20'h00031, 1'b1};
    tbl[17] = '{3, 8'h00, 8'h00, 20'h00003, 1'b1, 20'h00003, 1'b0};

    rst_n = 1'b0;
    iv    = '0;
    ordy  = '1;
    a     = '0;
    b     = '0;
    c     = '0;
    clr   = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    for (int k = 0; k < NI; k++) begin
      check($sformatf("rst_q_u%0d", k), 64'(q[k]), 64'd0);
      check($sformatf("rst_ov_u%0d", k), 64'(ov[k]), 64'd0);
      check($sformatf("rst_ovf_u%0d", k), 64'(ovf[k]), 64'd0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("rst_in_ready", 64'(ir), 64'(4'hF));

    // Back-to-back vectors per instance at full throughput
    for (int i = 0; i < NV; i++) begin
      send(tbl[i].k, tbl[i].a, tbl[i].b, tbl[i].c, tbl[i].clr, tbl[i].q, tbl[i].ovf,
           (tbl[i].k == 2) ? 3 : 2, 1'b1);
      if (i == NV - 1) idle(tbl[i].k);
      else if (tbl[i+1].k != tbl[i].k) idle(tbl[i].k);
    end
    drain();

    // Stall: consumer backs off for 3 cycles after the first result
    fork
      begin
        send(0, 8'd1, 8'd1, 20'd0, 1'b0, 20'd1, 1'b0, -1, 1'b1);
        send(0, 8'd2, 8'd2, 20'd0, 1'b0, 20'd4, 1'b0, -1, 1'b1);
        send(0, 8'd3, 8'd3, 20'd0, 1'b0, 20'd9, 1'b0, -1, 1'b1);
        send(0, 8'd4, 8'd4, 20'd0, 1'b1, 20'd16, 1'b0, -1, 1'b1);
        idle(0);
      end
      begin
        int            n;
        logic [CW-1:0] held;
        n = 0;
        do begin
          @(negedge clk);
          n++;
        end while (!ov[0] && n < 50);
        check("stall_first_valid", 64'(ov[0]), 64'd1);
        @(posedge clk);
        #1;
        ordy[0] = 1'b0;
        held    = q[0];
        for (int s = 0; s < 3; s++) begin
          @(negedge clk);
          check($sformatf("stall_in_ready_%0d", s), 64'(ir[0]), 64'd0);
          check($sformatf("stall_q_hold_%0d", s), 64'(q[0]), 64'(held));
          check($sformatf("stall_valid_%0d", s), 64'(ov[0]), 64'd1);
        end
        @(posedge clk);
        #1;
        ordy[0] = 1'b1;
      end
    join
    drain();

    // Reset with two beats in flight discards them and zeroes the accumulator
    send(3, 8'd0, 8'd0, 20'd50, 1'b1, 20'd50, 1'b0, 2, 1'b1);
    idle(3);
    drain();
    send(3, 8'd1, 8'd1, 20'd0, 1'b0, 20'd0, 1'b0, -1, 1'b0);
    send(3, 8'd2, 8'd2, 20'd0, 1'b0, 20'd0, 1'b0, -1, 1'b0);
    @(posedge clk);
    #1;
    iv[3] = 1'b0;
    check("inflight_valid", 64'(ov[3]), 64'd1);
    check("inflight_q", 64'(q[3]), 64'd51);
    rst_n = 1'b0;
    #1;
    check("midrst_ov", 64'(ov[3]), 64'd0);
    check("midrst_q", 64'(q[3]), 64'd0);
    check("midrst_ovf", 64'(ovf[3]), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    send(3, 8'd2, 8'd2, 20'd0, 1'b0, 20'd4, 1'b0, 2, 1'b1);
    idle(3);
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
